// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered pointers, occupancy count, almost flags and sticky errors.
// Define STREAM_FIFO_FWFT_EN for first-word-fall-through output; default is 1-cycle read latency.
module stream_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned AF_LEVEL   = 6,
   parameter int unsigned AE_LEVEL   = 1
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    clear,
   input  logic                    enq,
   input  logic [DATA_WIDTH-1:0]   enq_data,
   output logic                    full,
   output logic                    almost_full,
   input  logic                    deq,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    valid_out,
   output logic                    empty,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                  overflow_q, overflow_d, underflow_q, underflow_d;
   logic                  wr_en, rd_en;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Status is decoded purely from registered pointers.
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign count        = wr_ptr_q - rd_ptr_q;
   assign almost_full  = (32'(count) >= AF_LEVEL);
   assign almost_empty = (32'(count) <= AE_LEVEL);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   always_comb begin
      wr_en       = enq && !full && !clear;
      rd_en       = deq && !empty && !clear;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_en)         wr_ptr_d    = wr_ptr_q + 1'b1;
         if (rd_en)         rd_ptr_d    = rd_ptr_q + 1'b1;
         if (enq && full)   overflow_d  = 1'b1;
         if (deq && empty)  underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk_in) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= enq_data;
   end

`ifdef STREAM_FIFO_FWFT_EN
   assign data_out  = mem[rd_ptr_q[AW-1:0]];
   assign valid_out = !empty;
`else
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= rd_en;
         if (rd_en) data_q <= mem[rd_ptr_q[AW-1:0]];
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_stream_fifo;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AF    = 6;
   localparam int unsigned AE    = 1;

   logic          clk = 1'b0;
   logic          rst, clear, enq, deq;
   logic [DW-1:0] enq_data, data_out;
   logic          full, almost_full, valid_out, empty, almost_empty, overflow, underflow;
   logic [3:0]    count;

   int total = 0;
   int bad   = 0;

   stream_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AF),
      .AE_LEVEL   (AE)
   ) dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .clear        (clear),
      .enq          (enq),
      .enq_data     (enq_data),
      .full         (full),
      .almost_full  (almost_full),
      .deq          (deq),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .empty        (empty),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of stored words plus sticky flags and the last read word.
   logic [DW-1:0] mq[$];
   logic          m_ov, m_un, m_vld;
   logic [DW-1:0] m_dat;
   bit            m_full, m_empty, m_rd, m_wr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_ov = 1'b0; m_un = 1'b0; m_vld = 1'b0; m_dat = '0;
      end else if (clear) begin
         mq.delete();
         m_ov = 1'b0; m_un = 1'b0; m_vld = 1'b0;
      end else begin
         m_full  = (mq.size() == DEPTH);
         m_empty = (mq.size() == 0);
         m_rd    = deq && !m_empty;
         m_wr    = enq && !m_full;
         if (enq && m_full)  m_ov = 1'b1;
         if (deq && m_empty) m_un = 1'b1;
         m_vld = m_rd;
         if (m_rd) m_dat = mq.pop_front();
         if (m_wr) mq.push_back(enq_data);
      end
   end

   always @(negedge clk) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_un));
`ifdef STREAM_FIFO_FWFT_EN
      chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("data_out", 32'(data_out), 32'(mq[0]));
`else
      chk("valid_out", 32'(valid_out), 32'(m_vld));
      chk("data_out", 32'(data_out), 32'(m_dat));
`endif
   end

   // Inputs change just after a negedge; the call returns at the following negedge.
   task automatic step(input logic e, input logic [DW-1:0] d, input logic r, input logic c);
      enq = e; enq_data = d; deq = r; clear = c;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; enq = 1'b0; deq = 1'b0; enq_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_ae", 32'(almost_empty), 1);
      chk("rst_valid", 32'(valid_out), 0);
`ifndef STREAM_FIFO_FWFT_EN
      chk("rst_data", 32'(data_out), 0);
`endif
      rst = 1'b0;

      // 1: fill, then overflow
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, DW'(i), 1'b0, 1'b0);
         if (i == 5) chk("t1_af_at5", 32'(almost_full), 0);
         if (i == 6) chk("t1_af_at6", 32'(almost_full), 1);
      end
      chk("t1_full", 32'(full), 1);
      chk("t1_count8", 32'(count), 8);
      step(1'b1, 16'h0009, 1'b0, 1'b0);
      chk("t1_overflow", 32'(overflow), 1);
      chk("t1_count_hold", 32'(count), 8);

      // 2: drain in order, then underflow
      for (int i = 1; i <= 8; i++) begin
`ifdef STREAM_FIFO_FWFT_EN
         chk("t2_data", 32'(data_out), 32'(i));
         chk("t2_valid", 32'(valid_out), 1);
         step(1'b0, '0, 1'b1, 1'b0);
`else
         step(1'b0, '0, 1'b1, 1'b0);
         chk("t2_data", 32'(data_out), 32'(i));
         chk("t2_valid", 32'(valid_out), 1);
`endif
      end
      chk("t2_empty", 32'(empty), 1);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("t2_underflow", 32'(underflow), 1);
      chk("t2_no_valid", 32'(valid_out), 0);
`ifndef STREAM_FIFO_FWFT_EN
      chk("t2_data_hold", 32'(data_out), 8);
`endif

      // 3: pointer wrap
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0A00 + r * 5 + i), 1'b0, 1'b0);
         chk("t3_count5", 32'(count), 5);
         for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
`ifndef STREAM_FIFO_FWFT_EN
            chk("t3_data", 32'(data_out), 32'(16'h0A00 + r * 5 + i));
`endif
            if (i == 2) chk("t3_ae_at2", 32'(almost_empty), 0);
            if (i == 3) chk("t3_ae_at1", 32'(almost_empty), 1);
         end
      end

      // 4: steady state at 4, then simultaneous access while full
      for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h4000 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, DW'(16'h4100 + i), 1'b1, 1'b0);
      chk("t4_count4", 32'(count), 4);
      for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h4200 + i), 1'b0, 1'b0);
      chk("t4_count8", 32'(count), 8);
      step(1'b1, 16'h4300, 1'b1, 1'b0);
      chk("t4_count7", 32'(count), 7);
      chk("t4_overflow", 32'(overflow), 1);

      // 5: clear beats enq
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("t5_count5", 32'(count), 5);
      step(1'b1, 16'hDEAD, 1'b0, 1'b1);
      chk("t5_count0", 32'(count), 0);
      chk("t5_empty", 32'(empty), 1);
      chk("t5_ov_clr", 32'(overflow), 0);
      chk("t5_valid", 32'(valid_out), 0);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("t5_discard", 32'(count), 0);

      // 6: async reset mid-burst
      for (int i = 1; i <= 3; i++) step(1'b1, DW'(16'h6000 + i), 1'b0, 1'b0);
      enq = 1'b1; enq_data = 16'h6004;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_count", 32'(count), 0);
      chk("t6_empty", 32'(empty), 1);
      chk("t6_full", 32'(full), 0);
      chk("t6_ae", 32'(almost_empty), 1);
      chk("t6_af", 32'(almost_full), 0);
      chk("t6_valid", 32'(valid_out), 0);
      chk("t6_ov", 32'(overflow), 0);
      chk("t6_un", 32'(underflow), 0);
`ifndef STREAM_FIFO_FWFT_EN
      chk("t6_data", 32'(data_out), 0);
`endif
      @(negedge clk);
      enq = 1'b0;
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) step(1'b1, DW'(16'h7000 + i), 1'b0, 1'b0);
      chk("t6_count3", 32'(count), 3);
      for (int i = 1; i <= 3; i++) step(1'b0, '0, 1'b1, 1'b0);
`ifndef STREAM_FIFO_FWFT_EN
      chk("t6_last", 32'(data_out), 32'h7003);
`endif
      chk("t6_empty_end", 32'(empty), 1);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
